// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//   Built-in self-test sequencer for the regfile. On an accepted start it walks
//   entries 0..DATA_D-1. For each entry it spends three cycles:
//     WR  : writes pat(i)
//     RD  : presents the address with the write enable low
//     CMP : holds the address and compares rf_rdata against pat(i) at the end
//           of the cycle.
//   The compare point works for both combinational and 1-cycle registered
//   regfile reads. When the walk ends it raises done, and reports pass, a
//   saturating mismatch count and the first failing address.
//
//   Optional feature macro: REGFILE_BIST_INV_EN
//     When defined, a second full walk follows the first one using the
//     inverted pattern ~zext(i). Errors accumulate over both walks, and
//     first_err_addr keeps the earliest mismatch.
//     When undefined, only one walk runs and no walk-tracking flop exists.
//
// Handshake: start is a level input with no ready. It is acted on only in the
//   IDLE or DONE state. While busy=1 it is ignored.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-low reset
//   start           in   begin test (sampled in IDLE/DONE only)
//   busy            out  test running
//   done            out  test finished; held until the next accepted start
//   pass            out  valid while done=1; 1 = zero mismatches
//   err_cnt         out  mismatch count, saturating at all-ones
//   first_err_addr  out  address of the first mismatch; 0 if none
//   rf_we           out  regfile write enable
//   rf_addr         out  regfile address
//   rf_wdata        out  regfile write data
//   rf_rdata        in   regfile read data
//   dbg_state       out  current FSM state (IDLE=0 WR=1 RD=2 CMP=3 DONE=4)
// -----------------------------------------------------------------------------
module regfile_bist #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DATA_D = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_D - 1);
  // Number of address bits that fit in the data word.
  localparam int PW = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  // zext(a) truncated to DATA_W, optionally inverted.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic invert);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int b = 0; b < PW; b++) p[b] = a[b];
    return invert ? ~p : p;
  endfunction

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              busy_n, done_n, pass_n, we_n;
  logic [ADDR_W+1:0] err_n;
  logic [ADDR_W-1:0] ferr_n, addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              mismatch;
  logic              inv;

`ifdef REGFILE_BIST_INV_EN
  logic inv_n;
`else
  assign inv = 1'b0;
`endif

  assign dbg_state = state;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_cnt;
    ferr_n   = first_err_addr;
    we_n     = 1'b0;
    addr_n   = rf_addr;
    wdata_n  = '0;
`ifdef REGFILE_BIST_INV_EN
    inv_n    = inv;
`endif
    mismatch = (state == CMP) && (rf_rdata != pat(idx, inv));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WR;
          idx_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          ferr_n  = '0;
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = pat('0, 1'b0);
`ifdef REGFILE_BIST_INV_EN
          inv_n   = 1'b0;
`endif
        end
      end
      WR: begin
        state_n = RD;
      end
      RD: begin
        state_n = CMP;
      end
      CMP: begin
        if (mismatch) begin
          // err_cnt only returns to zero on start, so zero means "first one".
          if (err_cnt == '0) ferr_n = idx;
          if (!(&err_cnt)) err_n = err_cnt + 1'b1;
        end
        if (idx != LAST) begin
          state_n = WR;
          idx_n   = idx + 1'b1;
          we_n    = 1'b1;
          addr_n  = idx + 1'b1;
          wdata_n = pat(idx + 1'b1, inv);
        end
`ifdef REGFILE_BIST_INV_EN
        else if (!inv) begin
          state_n = WR;
          inv_n   = 1'b1;
          idx_n   = '0;
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = pat('0, 1'b1);
        end
`endif
        else begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          // err_n already includes the final compare.
          pass_n  = (err_n == '0);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      rf_we          <= 1'b0;
      rf_addr        <= '0;
      rf_wdata       <= '0;
`ifdef REGFILE_BIST_INV_EN
      inv            <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_cnt        <= err_n;
      first_err_addr <= ferr_n;
      rf_we          <= we_n;
      rf_addr        <= addr_n;
      rf_wdata       <= wdata_n;
`ifdef REGFILE_BIST_INV_EN
      inv            <= inv_n;
`endif
    end
  end

endmodule
